// File: rtl/redmule_mx_scale_fifo.sv
// redmule_mx_scale_fifo: MX beat buffer carrying NUM_LANES x BITW payload plus a
// shared-exponent sideband. Arbitrary depth, occupancy count, programmable
// almost-full/almost-empty flags, optional empty-FIFO fall-through and sticky
// overflow/underflow error flags.
module redmule_mx_scale_fifo #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned NUM_LANES    = 12,
    parameter int unsigned BITW         = 16,
    parameter int unsigned EXP_W        = 8,
    parameter int unsigned FALL_THROUGH = 0,
    parameter int unsigned AF_THRESH    = DEPTH - 1,
    parameter int unsigned AE_THRESH    = 1,
    localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        push_i,
    output logic                        grant_o,
    input  logic [NUM_LANES*BITW-1:0]   data_i,
    input  logic [EXP_W-1:0]            exp_i,
    input  logic                        pop_i,
    output logic                        valid_o,
    output logic [NUM_LANES*BITW-1:0]   data_o,
    output logic [EXP_W-1:0]            exp_o,
    output logic [CW-1:0]               count_o,
    output logic                        almost_full_o,
    output logic                        almost_empty_o,
    output logic                        overflow_o,
    output logic                        underflow_o
);

    localparam int unsigned DW = NUM_LANES * BITW;
    localparam int unsigned EW = EXP_W + DW;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage is never reset; only pointers and count define what is valid.
    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          full;
    logic          empty;
    logic          bypass;
    logic          push_acc;
    logic          pop_acc;
    logic          do_write;
    logic          do_read;
    logic [EW-1:0] head;

    // Pointer advance with wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Occupancy status, head selection and handshake decode.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        bypass   = (FALL_THROUGH != 0) && empty;
        // Grant depends only on registered state: no ready path from pop_i.
        grant_o  = ~full;
        valid_o  = bypass ? push_i : ~empty;
        head     = bypass ? {exp_i, data_i} : mem_q[rd_ptr_q];
        push_acc = push_i & ~full;
        pop_acc  = pop_i & valid_o;
        // A bypassed beat that is popped in the same cycle is never stored.
        do_write = push_acc & ~(bypass & pop_i) & ~clear_i;
        do_read  = pop_acc & ~bypass & ~clear_i;
    end

    assign data_o         = head[DW-1:0];
    assign exp_o          = head[EW-1:DW];
    assign count_o        = count_q;
    assign almost_full_o  = (32'(count_q) >= AF_THRESH);
    assign almost_empty_o = (32'(count_q) <= AE_THRESH);
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

    // Next-state for pointers, count and sticky error flags; clear has priority.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push_i & ~grant_o);
        unf_d    = unf_q | (pop_i & ~valid_o);

        if (do_write) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_read) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({do_write, do_read})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Beat storage write port.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= {exp_i, data_i};
        end
    end

endmodule

// File: tb/tb_redmule_mx_scale_fifo.sv
// Bench for redmule_mx_scale_fifo: a DEPTH=3 registered instance driven from a
// vector table, and a DEPTH=4 fall-through instance driven by hand sequences.
module tb_redmule_mx_scale_fifo;

    localparam int unsigned NL = 12;
    localparam int unsigned BW = 16;
    localparam int unsigned EW = 8;
    localparam int unsigned DW = NL * BW;

    logic clk;
    logic rst_n;

    // Instance A: DEPTH=3, registered output (AF_THRESH=2, AE_THRESH=1)
    logic          a_clear, a_push, a_pop;
    logic [DW-1:0] a_din;
    logic [EW-1:0] a_ein;
    logic          a_grant, a_valid, a_af, a_ae, a_ovf, a_unf;
    logic [DW-1:0] a_dout;
    logic [EW-1:0] a_eout;
    logic [1:0]    a_cnt;

    // Instance B: DEPTH=4, fall-through (AF_THRESH=3, AE_THRESH=1)
    logic          b_clear, b_push, b_pop;
    logic [DW-1:0] b_din;
    logic [EW-1:0] b_ein;
    logic          b_grant, b_valid, b_af, b_ae, b_ovf, b_unf;
    logic [DW-1:0] b_dout;
    logic [EW-1:0] b_eout;
    logic [2:0]    b_cnt;

    redmule_mx_scale_fifo #(
        .DEPTH(3), .NUM_LANES(NL), .BITW(BW), .EXP_W(EW), .FALL_THROUGH(0)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear),
        .push_i(a_push), .grant_o(a_grant), .data_i(a_din), .exp_i(a_ein),
        .pop_i(a_pop), .valid_o(a_valid), .data_o(a_dout), .exp_o(a_eout),
        .count_o(a_cnt), .almost_full_o(a_af), .almost_empty_o(a_ae),
        .overflow_o(a_ovf), .underflow_o(a_unf)
    );

    redmule_mx_scale_fifo #(
        .DEPTH(4), .NUM_LANES(NL), .BITW(BW), .EXP_W(EW), .FALL_THROUGH(1)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear),
        .push_i(b_push), .grant_o(b_grant), .data_i(b_din), .exp_i(b_ein),
        .pop_i(b_pop), .valid_o(b_valid), .data_o(b_dout), .exp_o(b_eout),
        .count_o(b_cnt), .almost_full_o(b_af), .almost_empty_o(b_ae),
        .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic push;
        logic pop;
        logic clear;
        int   din;
        logic valid;
        logic grant;
        int   cnt;
        logic af;
        logic ae;
        logic ovf;
        logic unf;
        int   head;   // expected head beat index, -1 = don't check data
    } vec_t;

    vec_t tv [64];
    int   nv = 0;

    function automatic logic [DW-1:0] beat(input int i);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < int'(NL); k++) begin
            d[k*BW +: BW] = 16'(32'hA000 + i * 16 + k);
        end
        return d;
    endfunction

    function automatic logic [EW-1:0] bexp(input int i);
        return 8'(32'h10 + i);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic add(input logic p, input logic q, input logic c, input int d,
                       input logic v, input logic g, input int cnt, input logic af,
                       input logic ae, input logic ov, input logic un, input int hd);
        tv[nv].push  = p;  tv[nv].pop  = q;  tv[nv].clear = c;  tv[nv].din = d;
        tv[nv].valid = v;  tv[nv].grant = g; tv[nv].cnt = cnt;  tv[nv].af = af;
        tv[nv].ae    = ae; tv[nv].ovf  = ov; tv[nv].unf = un;   tv[nv].head = hd;
        nv++;
    endtask

    task automatic chk_b_head(input string name, input int i);
        chk({name, "_b_data"}, b_dout, beat(i));
        chk({name, "_b_exp"}, DW'(b_eout), DW'(bexp(i)));
    endtask

    logic [DW-1:0] ft_x;

    initial begin
        rst_n   = 1'b0;
        a_clear = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_din = '0; a_ein = '0;
        b_clear = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_din = '0; b_ein = '0;

        // Stimulus table for instance A: outputs are the pre-edge values seen
        // while the listed inputs are applied.
        //   push pop clr din  valid grant cnt af ae ovf unf head
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0, -1);  // idle after reset
        add(1, 0, 0, 1,   0, 1, 0, 0, 1, 0, 0, -1);  // push A
        add(1, 0, 0, 2,   1, 1, 1, 0, 1, 0, 0,  1);  // push B
        add(1, 0, 0, 3,   1, 1, 2, 1, 0, 0, 0,  1);  // push C
        add(0, 0, 0, 0,   1, 0, 3, 1, 0, 0, 0,  1);  // full, grant low
        add(0, 1, 0, 0,   1, 0, 3, 1, 0, 0, 0,  1);  // pop A
        add(0, 1, 0, 0,   1, 1, 2, 1, 0, 0, 0,  2);  // pop B
        add(0, 1, 0, 0,   1, 1, 1, 0, 1, 0, 0,  3);  // pop C
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0, -1);  // empty again
        add(1, 0, 0, 4,   0, 1, 0, 0, 1, 0, 0, -1);  // first push of stream
        for (int i = 5; i <= 13; i++) begin
            add(1, 1, 0, i, 1, 1, 1, 0, 1, 0, 0, i - 1);  // streaming across wrap
        end
        add(0, 1, 0, 0,   1, 1, 1, 0, 1, 0, 0, 13);  // drain last
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0, -1);
        add(0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0, -1);  // pop on empty
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 1, -1);  // underflow sticky
        add(0, 0, 1, 0,   0, 1, 0, 0, 1, 0, 1, -1);  // clear
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0, -1);  // flag cleared
        add(1, 0, 0, 20,  0, 1, 0, 0, 1, 0, 0, -1);
        add(1, 0, 0, 21,  1, 1, 1, 0, 1, 0, 0, 20);
        add(1, 0, 0, 22,  1, 1, 2, 1, 0, 0, 0, 20);
        add(1, 0, 0, 23,  1, 0, 3, 1, 0, 0, 0, 20);  // push while full
        add(1, 1, 0, 24,  1, 0, 3, 1, 0, 1, 0, 20);  // full: pop ok, push rejected
        add(0, 0, 0, 0,   1, 1, 2, 1, 0, 1, 0, 21);  // grant back
        add(1, 0, 1, 25,  1, 1, 2, 1, 0, 1, 0, 21);  // clear with push
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0, -1);  // flushed

        // Reset values, checked while reset is held.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_cnt",   DW'(a_cnt),   DW'(0));
        chk("rst_a_grant", DW'(a_grant), DW'(1));
        chk("rst_a_valid", DW'(a_valid), DW'(0));
        chk("rst_a_ae",    DW'(a_ae),    DW'(1));
        chk("rst_a_af",    DW'(a_af),    DW'(0));
        chk("rst_b_cnt",   DW'(b_cnt),   DW'(0));
        chk("rst_b_valid", DW'(b_valid), DW'(0));
        chk("rst_b_ovf",   DW'(b_ovf),   DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < nv; v++) begin
            @(negedge clk);
            a_push  = tv[v].push;
            a_pop   = tv[v].pop;
            a_clear = tv[v].clear;
            a_din   = beat(tv[v].din);
            a_ein   = bexp(tv[v].din);
            #1;
            chk($sformatf("v%0d_valid", v), DW'(a_valid), DW'(tv[v].valid));
            chk($sformatf("v%0d_grant", v), DW'(a_grant), DW'(tv[v].grant));
            chk($sformatf("v%0d_cnt", v),   DW'(a_cnt),   DW'(tv[v].cnt));
            chk($sformatf("v%0d_af", v),    DW'(a_af),    DW'(tv[v].af));
            chk($sformatf("v%0d_ae", v),    DW'(a_ae),    DW'(tv[v].ae));
            chk($sformatf("v%0d_ovf", v),   DW'(a_ovf),   DW'(tv[v].ovf));
            chk($sformatf("v%0d_unf", v),   DW'(a_unf),   DW'(tv[v].unf));
            if (tv[v].head >= 0) begin
                chk($sformatf("v%0d_data", v), a_dout, beat(tv[v].head));
                chk($sformatf("v%0d_exp", v),  DW'(a_eout), DW'(bexp(tv[v].head)));
            end
        end
        @(negedge clk);
        a_push = 1'b0; a_pop = 1'b0; a_clear = 1'b0;

        // Fall-through on empty: push+pop consumes in the same cycle.
        for (int k = 0; k < int'(NL); k++) ft_x[k*BW +: BW] = 16'(32'h0ABC + k);
        b_push = 1'b1; b_pop = 1'b1; b_din = ft_x; b_ein = 8'h7F;
        #1;
        chk("ft_valid", DW'(b_valid), DW'(1));
        chk("ft_data",  b_dout, ft_x);
        chk("ft_exp",   DW'(b_eout), DW'(8'h7F));
        chk("ft_cnt",   DW'(b_cnt), DW'(0));
        @(negedge clk);
        b_pop = 1'b0; b_din = beat(40); b_ein = bexp(40);
        #1;
        chk("ft_cnt_after_bypass", DW'(b_cnt), DW'(0));
        chk_b_head("ft_nopop", 40);
        @(negedge clk);
        b_din = beat(41); b_ein = bexp(41);
        #1;
        chk("ft_cnt_stored", DW'(b_cnt), DW'(1));
        chk_b_head("ft_stored", 40);
        @(negedge clk);
        b_din = beat(42); b_ein = bexp(42);
        @(negedge clk);
        b_din = beat(43); b_ein = bexp(43);
        @(negedge clk);
        b_push = 1'b0;
        #1;
        chk("b_full_cnt",   DW'(b_cnt),   DW'(4));
        chk("b_full_grant", DW'(b_grant), DW'(0));
        chk("b_full_af",    DW'(b_af),    DW'(1));

        // Full with push and pop together: pop proceeds, push rejected.
        @(negedge clk);
        b_push = 1'b1; b_pop = 1'b1; b_din = beat(44); b_ein = bexp(44);
        #1;
        chk("b_fp_grant", DW'(b_grant), DW'(0));
        chk_b_head("b_fp", 40);
        @(negedge clk);
        b_push = 1'b0; b_pop = 1'b0;
        #1;
        chk("b_fp_cnt",   DW'(b_cnt),   DW'(3));
        chk("b_fp_grant_back", DW'(b_grant), DW'(1));
        chk("b_fp_ovf",   DW'(b_ovf),   DW'(1));
        chk_b_head("b_fp_next", 41);

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        a_push = 1'b1; a_din = beat(50); a_ein = bexp(50);
        b_push = 1'b1; b_din = beat(51); b_ein = bexp(51);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a_cnt",   DW'(a_cnt),   DW'(0));
        chk("arst_a_valid", DW'(a_valid), DW'(0));
        chk("arst_a_grant", DW'(a_grant), DW'(1));
        chk("arst_a_ae",    DW'(a_ae),    DW'(1));
        chk("arst_b_cnt",   DW'(b_cnt),   DW'(0));
        chk("arst_b_ovf",   DW'(b_ovf),   DW'(0));
        chk("arst_b_af",    DW'(b_af),    DW'(0));
        chk("arst_b_valid", DW'(b_valid), DW'(1));
        chk("arst_b_data",  b_dout, beat(51));
        a_push = 1'b0; b_push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/redmule_mx_scale_fifo.md
# redmule_mx_scale_fifo

Parametrised successor to the MX lane FIFO: buffers MX data beats (NUM_LANES × BITW payload) together with their shared-exponent sideband. Adds non-power-of-two depth, occupancy count, programmable almost-full/almost-empty flags, optional fall-through mode and sticky overflow/underflow error flags. Sits between the MX decode/stream stages and the RedMulE datapath feeders.

## Interface
- DEPTH, 4: number of entries, ≥2, need not be a power of two.
- NUM_LANES, 12: payload lanes per beat.
- BITW, 16: bits per lane.
- EXP_W, 8: shared-exponent sideband width.
- FALL_THROUGH, 0: 1 = empty-FIFO bypass from push to pop side in the same cycle.
- AF_THRESH, DEPTH-1: almost_full_o asserts when count ≥ AF_THRESH.
- AE_THRESH, 1: almost_empty_o asserts when count ≤ AE_THRESH.
- CW (local), $clog2(DEPTH+1): count width.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush; empties the FIFO and clears error flags.
- push_i  in  1  producer valid.
- grant_o  out  1  producer ready; = ~full.
- data_i  in  NUM_LANES×BITW  payload beat.
- exp_i  in  EXP_W  shared exponent of the beat.
- pop_i  in  1  consumer ready.
- valid_o  out  1  consumer valid.
- data_o  out  NUM_LANES×BITW  head payload.
- exp_o  out  EXP_W  head exponent.
- count_o  out  CW  stored entries, 0..DEPTH.
- almost_full_o  out  1  count_o ≥ AF_THRESH.
- almost_empty_o  out  1  count_o ≤ AE_THRESH.
- overflow_o  out  1  sticky: push_i high while grant_o low.
- underflow_o  out  1  sticky: pop_i high while valid_o low.

## Operation
- Storage: DEPTH entries of {exp, payload}; rd_ptr, wr_ptr in 0..DEPTH-1, increment wrapping from DEPTH-1 to 0; explicit count register (0..DEPTH) derives full (count==DEPTH) and empty (count==0).
- Push accepted when push_i & grant_o; pop accepted when pop_i & valid_o.
- Non-bypass mode: valid_o = ~empty; data_o/exp_o = entry at rd_ptr (combinational read).
- FALL_THROUGH=1 and empty: valid_o = push_i, data_o/exp_o = data_i/exp_i; if pop_i also high, beat is consumed without being written, pointers and count unchanged. If pop_i low, beat is written normally.
- Simultaneous accepted push and pop with count in 1..DEPTH-1: both pointers advance, count unchanged.
- Full: grant_o = 0 even if pop_i high (grant never depends on pop_i, no combinational ready loop); the pop proceeds, grant_o returns next cycle.
- Rejected push or pop: no state change except sticky error flag set.
- clear_i: pointers and count to 0, overflow_o/underflow_o to 0; push/pop in the same cycle ignored, error detection in that cycle suppressed. Storage contents not reset.
- Error flags: set on the violating cycle's edge, held until clear_i or reset.

## Timing
- Reset (async, rst_ni low): count_o=0, grant_o=1, valid_o=0 (or =push_i in fall-through), almost_empty_o=1 (AE_THRESH≥0), almost_full_o=0, overflow_o=0, underflow_o=0; data_o/exp_o undefined.
- Reset asserted mid-operation discards all entries immediately; no partial push is retained.
- Latency push→valid_o: 1 cycle (non-bypass), 0 cycles (fall-through, empty).
- count_o, flags, grant_o update on the clock edge following the accepted event; all registered-state outputs are glitch-free functions of registers (except fall-through valid/data path).
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset, DEPTH=3: push beats A,B,C on consecutive cycles -> count_o 1,2,3; grant_o=0 after C; almost_full_o=1 from count 2; pop three -> A,B,C in order, exp_o matching, count_o back to 0.
- Wrap, DEPTH=3: 10 beats with continuous push+pop after first push -> count_o stays 1, output order intact across pointer wrap 2→0.
- Full plus pop, DEPTH=4: fill, then push_i=pop_i=1 -> pop accepted, push rejected, overflow_o=1, count_o=3, grant_o=1 next cycle.
- Underflow: pop_i=1 on empty -> underflow_o=1, count_o=0; clear_i one cycle -> both flags 0.
- FALL_THROUGH=1, empty: push_i=pop_i=1, data_i=0x0ABC.., exp_i=0x7F -> valid_o=1, data_o/exp_o equal inputs same cycle, count_o stays 0; with pop_i=0 -> count_o=1.
- clear_i with count 2 and simultaneous push -> count_o=0, valid_o=0 next cycle; async rst_ni low mid-burst -> all outputs at reset values immediately.
